lr3_btn_fltr_n: RTL and testbench
=================================

# lr3_btn_fltr_n

Parametrised N-channel push-button conditioner replacing the single-button filter in the LR3 top level. Each channel synchronises a raw button input, debounces it against a clock-enable tick, and produces a debounced level plus one-clock press and release strobes. An optional auto-repeat strobe can be compiled in for held buttons. It sits between the board pins and the LR3 datapath and is driven by the shared CE generator.

## Interface
- N_BTN, 4, number of independent button channels (1..16)
- FLT_CNT, 8, consecutive stable CE ticks required to accept a level change (1..255)
- REP_DLY, 50, CE ticks held before the first repeat strobe (1..1023, auto-repeat build only)
- REP_PER, 10, CE ticks between subsequent repeat strobes (1..1023, auto-repeat build only)
- ACT_LVL, 1, raw input level meaning "pressed" (1 or 0)

- CLK  in  1  system clock; all state on rising edge
- RST  in  1  asynchronous, active-high reset
- CE  in  1  filter tick from the CE generator; one CLK wide
- BTN_I  in  N_BTN  raw button pins, asynchronous to CLK
- BTN_O  out  N_BTN  debounced level, 1 = pressed
- BTN_CEO  out  N_BTN  press strobe, one CLK cycle
- BTN_REL  out  N_BTN  release strobe, one CLK cycle
- BTN_REP  out  N_BTN  auto-repeat strobe, one CLK cycle (constant 0 when feature absent)
- BTN_ANY  out  1  OR of BTN_O

## Operation
- Per channel: 2-flop synchroniser, then XOR with ~ACT_LVL to normalise, giving `s` (1 = pressed).
- Per-channel FSM, advancing only on CLK edges with CE=1:
  - IDLE: s=1 -> PCHK, cnt=1 (if FLT_CNT=1, go directly to HELD and press).
  - PCHK: s=0 -> IDLE, cnt=0. s=1 -> cnt+1; on reaching FLT_CNT -> HELD, fire press.
  - HELD: s=0 -> RCHK, cnt=1 (if FLT_CNT=1, go directly to IDLE and release).
  - RCHK: s=1 -> HELD, cnt=0. s=0 -> cnt+1; on reaching FLT_CNT -> IDLE, fire release.
- BTN_O=1 in HELD and RCHK, otherwise 0.
- Each bounce resets the count. No strobe fires on an aborted check.
- cnt width is clog2(FLT_CNT+1) and never exceeds FLT_CNT.
- Channels are fully independent. Simultaneous events on several channels each fire in the same cycle.

## Timing
- Reset: all FSMs IDLE, counters 0, synchronisers at the released level. BTN_O, BTN_CEO, BTN_REL, BTN_REP and BTN_ANY are all 0.
- Input latency: 2 CLK for synchronisation. Acceptance then takes FLT_CNT further CE ticks.
- Strobes are registered. They are high for exactly the one CLK cycle after the CE edge that caused the transition.
- BTN_O changes on that same edge, so it rises together with BTN_CEO.
- CE held high continuously is legal: debounce then counts CLK cycles.
- CE=0: state frozen, no strobes, synchroniser still runs.
- RST asserted mid-press forces IDLE immediately, with no release strobe. After deassertion, a still-pressed input must re-qualify (full FLT_CNT) before a press strobe fires.

## Configuration
- BTN_AUTOREP_EN defined: per-channel repeat counter runs in HELD only, on CE ticks.
  - BTN_REP pulses once after REP_DLY ticks, then every REP_PER ticks.
  - The counter clears on leaving HELD. RCHK pauses it; a return to HELD resumes from the held value.
- BTN_AUTOREP_EN undefined: no repeat counters are synthesised, BTN_REP is tied to 0, and REP_DLY/REP_PER are ignored.

## Structure
- Package lr3_btn_pkg: FSM state enum (IDLE, PCHK, HELD, RCHK), clog2-based width function, default FLT_CNT/REP_* constants.
- Sub-module lr3_btn_chan: one channel (synchroniser, FSM, filter counter, optional repeat counter). The top instantiates it N_BTN times with a generate loop and ORs the BTN_O outputs into BTN_ANY.

## Test plan
- Reset with BTN_I=4'b0001 held, release RST, CE every 4 CLK, FLT_CNT=8 -> no strobe until the 8th CE after sync. Then BTN_CEO[0] is high for 1 CLK and BTN_O[0]=1.
- Bounce on ch1: 5 CE high, 1 CE low, 8 CE high -> exactly one BTN_CEO[1], on the 8th tick of the final run.
- Release after hold, FLT_CNT=8 -> BTN_REL pulses once, 8 CE ticks after the input falls. BTN_O falls on the same edge.
- Simultaneous press of all 4 channels -> BTN_CEO=4'b1111 in one cycle and BTN_ANY=1.
- RST pulse while ch2 is in HELD -> BTN_O[2]=0 immediately and BTN_REL[2] never pulses. A full re-qualification is required afterwards.
- BTN_AUTOREP_EN, REP_DLY=50, REP_PER=10, hold 100 CE -> BTN_REP pulses at ticks 50, 60, 70, 80, 90, 100 after acceptance. Without the macro, BTN_REP stays 0.

Source files
------------

// File: rtl/lr3_btn_pkg.sv
// Shared types and helpers for the LR3 push-button conditioner.
// Channel FSM states, counter-width helper and default timing constants.
package lr3_btn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PCHK = 2'd1,
        HELD = 2'd2,
        RCHK = 2'd3
    } btn_state_t;

    localparam int DEF_FLT_CNT = 8;
    localparam int DEF_REP_DLY = 50;
    localparam int DEF_REP_PER = 10;

    // Bits needed to hold 0..max_val inclusive; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lr3_btn_chan.sv
// One button channel: 2-flop synchroniser, CE-gated debounce FSM, registered strobes.
// Auto-repeat counter is built only when BTN_AUTOREP_EN is defined.
//
// state | meaning
// IDLE  | released, waiting for a pressed sample
// PCHK  | counting stable pressed ticks toward acceptance
// HELD  | accepted press, level high
// RCHK  | counting stable released ticks toward release
module lr3_btn_chan
    import lr3_btn_pkg::*;
#(
    parameter int FLT_CNT = DEF_FLT_CNT,
    parameter int REP_DLY = DEF_REP_DLY,
    parameter int REP_PER = DEF_REP_PER,
    parameter bit ACT_LVL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic btn_raw,
    output logic level,
    output logic press_stb,
    output logic rel_stb,
    output logic rep_stb
);

    localparam int CW = cnt_width(FLT_CNT);
    localparam logic [CW-1:0] FLT_MAX = CW'(FLT_CNT);

    logic [1:0]    sync_q;
    logic          s;
    btn_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          press_d, rel_d;

    // Synchroniser idles at the released pin level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {2{~ACT_LVL}};
        else     sync_q <= {sync_q[0], btn_raw};
    end

    assign s       = sync_q[1] ^ ~ACT_LVL;
    assign cnt_inc = cnt_q + CW'(1);
    assign level   = (state_q == HELD) || (state_q == RCHK);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (ce) begin
            case (state_q)
                IDLE: if (s) begin
                    if (FLT_CNT == 1) begin
                        state_d = HELD;
                        press_d = 1'b1;
                    end else begin
                        state_d = PCHK;
                        cnt_d   = CW'(1);
                    end
                end
                PCHK: if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_inc == FLT_MAX) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
                HELD: if (!s) begin
                    if (FLT_CNT == 1) begin
                        state_d = IDLE;
                        rel_d   = 1'b1;
                    end else begin
                        state_d = RCHK;
                        cnt_d   = CW'(1);
                    end
                end
                RCHK: if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_inc == FLT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_stb <= 1'b0;
            rel_stb   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_stb <= press_d;
            rel_stb   <= rel_d;
        end
    end

`ifdef BTN_AUTOREP_EN
    localparam int RW = cnt_width((REP_DLY > REP_PER) ? REP_DLY : REP_PER);
    localparam logic [RW-1:0] DLY_MAX = RW'(REP_DLY);
    localparam logic [RW-1:0] PER_MAX = RW'(REP_PER);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
    logic          rep_first_q, rep_first_d, rep_d;

    assign rep_inc = rep_cnt_q + RW'(1);

    // Counts only ticks that keep the channel in HELD; RCHK holds the value, IDLE clears it.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_d       = 1'b0;
        if (state_d == IDLE) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
        end else if (ce && state_q == HELD && state_d == HELD) begin
            if (!rep_first_q && rep_inc == DLY_MAX) begin
                rep_d       = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b1;
            end else if (rep_first_q && rep_inc == PER_MAX) begin
                rep_d     = 1'b1;
                rep_cnt_d = '0;
            end else begin
                rep_cnt_d = rep_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
            rep_stb     <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            rep_stb     <= rep_d;
        end
    end
`else
    assign rep_stb = 1'b0;
`endif

endmodule

// File: rtl/lr3_btn_fltr_n.sv
// N-channel push-button conditioner for the LR3 top level.
// Define BTN_AUTOREP_EN to build the per-channel auto-repeat strobe.
module lr3_btn_fltr_n
    import lr3_btn_pkg::*;
#(
    parameter int N_BTN   = 4,
    parameter int FLT_CNT = DEF_FLT_CNT,
    parameter int REP_DLY = DEF_REP_DLY,
    parameter int REP_PER = DEF_REP_PER,
    parameter bit ACT_LVL = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [N_BTN-1:0] BTN_I,
    output logic [N_BTN-1:0] BTN_O,
    output logic [N_BTN-1:0] BTN_CEO,
    output logic [N_BTN-1:0] BTN_REL,
    output logic [N_BTN-1:0] BTN_REP,
    output logic             BTN_ANY
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        lr3_btn_chan #(
            .FLT_CNT (FLT_CNT),
            .REP_DLY (REP_DLY),
            .REP_PER (REP_PER),
            .ACT_LVL (ACT_LVL)
        ) u_chan (
            .clk       (CLK),
            .rst       (RST),
            .ce        (CE),
            .btn_raw   (BTN_I[i]),
            .level     (BTN_O[i]),
            .press_stb (BTN_CEO[i]),
            .rel_stb   (BTN_REL[i]),
            .rep_stb   (BTN_REP[i])
        );
    end

    assign BTN_ANY = |BTN_O;

endmodule

// File: tb/tb_lr3_btn_fltr_n.sv
// Scoreboard bench for lr3_btn_fltr_n (4 channels, FLT_CNT=8, CE every 4 CLK).
// Expected strobes are queued with the CE tick index of the edge that causes them.
module tb_lr3_btn_fltr_n;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CE  = 1'b0;
    logic [3:0] BTN_I = 4'b0001;
    logic [3:0] BTN_O, BTN_CEO, BTN_REL, BTN_REP;
    logic       BTN_ANY;

    lr3_btn_fltr_n #(
        .N_BTN   (4),
        .FLT_CNT (8),
        .REP_DLY (50),
        .REP_PER (10),
        .ACT_LVL (1'b1)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .CE      (CE),
        .BTN_I   (BTN_I),
        .BTN_O   (BTN_O),
        .BTN_CEO (BTN_CEO),
        .BTN_REL (BTN_REL),
        .BTN_REP (BTN_REP),
        .BTN_ANY (BTN_ANY)
    );

    typedef struct {
        int         tick;
        logic [3:0] ceo;
        logic [3:0] rel;
        logic [3:0] rep;
        logic [3:0] o;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   tk    = 0;
    int   rep_seen = 0;
    int   ph    = 0;

    initial forever #5 CLK = ~CLK;

    initial forever begin
        @(negedge CLK);
        ph = (ph + 1) % 4;
        CE = (ph == 0);
    end

    always @(posedge CLK) if (CE) tk <= tk + 1;

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            while (!CE) @(posedge CLK);
        end
        #1;
    endtask

    task automatic push(input int t, input logic [3:0] ceo, input logic [3:0] rel,
                        input logic [3:0] rep, input logic [3:0] o);
        exp_t e;
        e.tick = t; e.ceo = ceo; e.rel = rel; e.rep = rep; e.o = o;
        q.push_back(e);
    endtask

    // Monitor: every strobe cycle must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (!RST && (BTN_CEO != 4'b0 || BTN_REL != 4'b0 || BTN_REP != 4'b0)) begin
            rep_seen += $countones(BTN_REP);
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe tick=%0d ceo=%b rel=%b rep=%b o=%b",
                         tk, BTN_CEO, BTN_REL, BTN_REP, BTN_O);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (tk != e.tick || BTN_CEO != e.ceo || BTN_REL != e.rel ||
                    BTN_REP != e.rep || BTN_O != e.o || BTN_ANY != (|e.o)) begin
                    bad++;
                    $display("FAIL strobe got tick=%0d ceo=%b rel=%b rep=%b o=%b any=%b want tick=%0d ceo=%b rel=%b rep=%b o=%b any=%b",
                             tk, BTN_CEO, BTN_REL, BTN_REP, BTN_O, BTN_ANY,
                             e.tick, e.ceo, e.rel, e.rep, e.o, |e.o);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog tick=%0d", tk);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, j, m, p, r, a, exp_rep;
        exp_rep = 0;

        // Reset with ch0 pressed: everything must read zero.
        wait_ticks(3);
        total++;
        if ({BTN_O, BTN_CEO, BTN_REL, BTN_REP, BTN_ANY} != 17'b0) begin
            bad++;
            $display("FAIL reset_state got o=%b ceo=%b rel=%b rep=%b any=%b want all 0",
                     BTN_O, BTN_CEO, BTN_REL, BTN_REP, BTN_ANY);
        end
        RST = 1'b0;
        k = tk;
        push(k + 8, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        wait_ticks(10);

        // Bounce on ch1: 5 high, 1 low, 8 high.
        j = tk;
        BTN_I[1] = 1'b1;
        wait_ticks(5);
        BTN_I[1] = 1'b0;
        wait_ticks(1);
        BTN_I[1] = 1'b1;
        push(j + 14, 4'b0010, 4'b0000, 4'b0000, 4'b0011);
        wait_ticks(10);

        // Staggered release of ch0 then ch1.
        m = tk;
        BTN_I[0] = 1'b0;
        push(m + 8, 4'b0000, 4'b0001, 4'b0000, 4'b0010);
        wait_ticks(2);
        BTN_I[1] = 1'b0;
        push(m + 10, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        wait_ticks(12);

        // Simultaneous press of all channels.
        p = tk;
        BTN_I = 4'b1111;
        push(p + 8, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        wait_ticks(11);

        // Reset while held: level drops at once, no release strobe.
        RST = 1'b1;
        #1;
        total++;
        if (BTN_O != 4'b0 || BTN_ANY != 1'b0 || BTN_REL != 4'b0) begin
            bad++;
            $display("FAIL rst_mid_press got o=%b any=%b rel=%b want 0 0 0", BTN_O, BTN_ANY, BTN_REL);
        end
        wait_ticks(2);
        RST = 1'b0;
        p = tk;
        push(p + 8, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        wait_ticks(10);
        r = tk;
        BTN_I = 4'b0000;
        push(r + 8, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        wait_ticks(10);

        // Long hold on ch3: 100 ticks after acceptance.
        a = tk;
        BTN_I[3] = 1'b1;
        push(a + 8, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
`ifdef BTN_AUTOREP_EN
        for (int i = 0; i < 6; i++)
            push(a + 58 + 10 * i, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
        exp_rep = 6;
`endif
        wait_ticks(108);
        BTN_I[3] = 1'b0;
        push(a + 116, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
        wait_ticks(12);

        total++;
        if (rep_seen != exp_rep) begin
            bad++;
            $display("FAIL rep_count got %0d want %0d", rep_seen, exp_rep);
        end

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL missing_strobes got pending=%0d want 0 first_tick=%0d", q.size(), q[0].tick);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
